// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encodings and nominal line timings in ns,
// used by both the transmitter and the receiver.
package ws2812_pkg;

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    localparam int T0H_NS    = 350;
    localparam int T1H_NS    = 700;
    localparam int THRESH_NS = 550;
    localparam int LATCH_NS  = 50000;
    localparam int STUCK_NS  = 5000;

    // Truncating ns -> clock-cycle conversion for a clock given in MHz.
    function automatic int ns_to_cyc(input int mhz, input int ns);
        return mhz * ns / 1000;
    endfunction

endpackage

// File: rtl/ws2812_sync.sv
// Two-flop synchroniser for the WS2812 line, with rise/fall strobes registered so that
// they line up with the cycle in which the synchronised level first changes.
module ws2812_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
            rise <= meta & ~dout;
            fall <= ~meta & dout;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 line decoder: measures high pulse widths to recover bits, assembles 24-bit
// pixels and reports frame boundaries on the line-low latch.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_MHZ  = 12,
    parameter int NUM_LEDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic [7:0]  pixel_count,
    output logic        overflow,
    output logic        err
);

    localparam int T_THRESH = ns_to_cyc(CLK_MHZ, THRESH_NS);
    localparam int T_LATCH  = ns_to_cyc(CLK_MHZ, LATCH_NS);
    localparam int T_STUCK  = ns_to_cyc(CLK_MHZ, STUCK_NS);
    // One counter serves both phases; the latch period is the longest interval timed.
    localparam int CW = $clog2(T_LATCH + 1);
    localparam logic [CW-1:0] THRESH   = CW'(T_THRESH);
    localparam logic [CW-1:0] LATCH_M1 = CW'(T_LATCH - 1);
    localparam logic [CW-1:0] STUCK_M1 = CW'(T_STUCK - 1);
    localparam logic [8:0]    NLED     = 9'(NUM_LEDS);

    logic          data_s, rise, fall;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_cnt;
    logic [22:0]   shreg;
    logic [7:0]    pix_idx;
    logic          bit_val;
    logic [23:0]   word;

    ws2812_sync u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (data),
        .dout   (data_s),
        .rise   (rise),
        .fall   (fall)
    );

    assign bit_val = (cnt >= THRESH);
    assign word    = {shreg, bit_val};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_SYNC;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            pix_idx     <= '0;
            rgb_data    <= '0;
            led_num     <= '0;
            pixel_count <= '0;
            valid       <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            err         <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (data_s) begin
                        cnt <= '0;
                    end else if (cnt == LATCH_M1) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (rise) begin
                        cnt   <= '0;
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        cnt   <= '0;
                        state <= S_LOW;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            if ({1'b0, pix_idx} < NLED) begin
                                rgb_data <= word;
                                led_num  <= pix_idx;
                                valid    <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                            if (pix_idx != 8'hFF)
                                pix_idx <= pix_idx + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= word[22:0];
                        end
                    end else if (cnt == STUCK_M1) begin
                        // Line stuck high: drop the partial pixel and resynchronise.
                        err     <= 1'b1;
                        bit_cnt <= '0;
                        cnt     <= '0;
                        state   <= S_SYNC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin // S_LOW
                    if (rise) begin
                        cnt   <= '0;
                        state <= S_HIGH;
                    end else if (cnt == LATCH_M1) begin
                        frame_done  <= 1'b1;
                        pixel_count <= ({1'b0, pix_idx} > NLED) ? NLED[7:0] : pix_idx;
                        pix_idx     <= '0;
                        overflow    <= 1'b0;
                        err         <= (bit_cnt != 5'd0);
                        bit_cnt     <= '0;
                        cnt         <= '0;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
